// File: rtl/signed_mul_seq.sv
// Sequential signed multiplier: operands are reduced to magnitudes, multiplied by a
// WIDTH-step shift-add loop, then the product sign is restored by a two's-complement negate.
module signed_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS,
        S_MUL,
        S_FIX,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_neg;
    logic [WIDTH-1:0] r_mag_a;
    logic [WIDTH-1:0] r_mag_b;
    logic [PW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic [PW-1:0]    r_product;

    logic             w_accept;
    logic             w_last_iter;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [PW-1:0]    w_addend;
    logic [PW-1:0]    w_fixed;

    // Handshake flags come straight from the state register, so neither
    // in_valid nor out_ready has a combinational path to an output.
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign product   = r_product;

    assign w_accept    = in_valid && (r_state == S_IDLE);
    assign w_last_iter = (r_cnt == CW'(WIDTH - 1));

    // Most negative operand maps onto itself, which reads correctly as unsigned 2^(WIDTH-1).
    assign w_mag_a = r_a[WIDTH-1] ? (~r_a + WIDTH'(1)) : r_a;
    assign w_mag_b = r_b[WIDTH-1] ? (~r_b + WIDTH'(1)) : r_b;

    assign w_addend = r_mag_b[r_cnt] ? ({{WIDTH{1'b0}}, r_mag_a} << r_cnt) : '0;
    assign w_fixed  = r_neg ? (~r_acc + PW'(1)) : r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = S_ABS;
            S_ABS:  w_state_next = S_MUL;
            S_MUL:  if (w_last_iter) w_state_next = S_FIX;
            S_FIX:  w_state_next = S_DONE;
            S_DONE: if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_neg     <= 1'b0;
            r_mag_a   <= '0;
            r_mag_b   <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_neg <= a[WIDTH-1] ^ b[WIDTH-1];
                    end
                end
                S_ABS: begin
                    r_mag_a <= w_mag_a;
                    r_mag_b <= w_mag_b;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                end
                S_MUL: begin
                    // Sum of partial products never exceeds 2^(2*WIDTH-2), so no carry-out.
                    r_acc <= r_acc + w_addend;
                    r_cnt <= r_cnt + CW'(1);
                end
                S_FIX: begin
                    r_product <= w_fixed;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
